// File: rtl/nodf_handshake_monitor.sv
// Status monitor for one non-dataflow HLS block's ap_start/ap_ready/ap_done/ap_continue
// handshake: transaction state, event counts, latency, start interval and stall statistics.
module nodf_handshake_monitor #(
  parameter int CNT_W = 32,
  parameter int TXN_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
  output logic [1:0]       state,
  output logic             start_evt,
  output logic             done_evt,
  output logic [TXN_W-1:0] txn_count,
  output logic [TXN_W-1:0] ready_count,
  output logic [CNT_W-1:0] last_latency,
  output logic [CNT_W-1:0] min_latency,
  output logic [CNT_W-1:0] max_latency,
  output logic [CNT_W-1:0] last_interval,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] cycle_count,
  output logic             frozen,
  output logic             spurious_done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    WAIT_CONT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  localparam logic [TXN_W-1:0] T_ONE = TXN_W'(1);

  state_t           st;
  logic [CNT_W-1:0] lat_cnt;     // cycles of the open transaction, start cycle included
  logic [CNT_W-1:0] int_cnt;     // cycles since the most recent start, start cycle included
  logic             seen_start;
  logic             start_acc;
  logic             complete;
  logic [CNT_W-1:0] lat_now;

  function automatic logic [CNT_W-1:0] inc_c(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + C_ONE;
  endfunction

  function automatic logic [TXN_W-1:0] inc_t(input logic [TXN_W-1:0] v);
    return (&v) ? v : v + T_ONE;
  endfunction

  // NOTE: every signal gets a default on entry so no path through this block infers a latch.
  always_comb begin
    start_acc = 1'b0;
    complete  = 1'b0;
    lat_now   = C_ONE;
    start_acc = (st == IDLE) && ap_start;
    complete  = ap_done && ((st == RUN) || start_acc);
    if (!start_acc) lat_now = inc_c(lat_cnt);
  end

  assign state = st;

  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st            <= IDLE;
      start_evt     <= 1'b0;
      done_evt      <= 1'b0;
      txn_count     <= '0;
      ready_count   <= '0;
      last_latency  <= '0;
      min_latency   <= '1;
      max_latency   <= '0;
      last_interval <= '0;
      stall_cycles  <= '0;
      cycle_count   <= '0;
      frozen        <= 1'b0;
      spurious_done <= 1'b0;
      lat_cnt       <= '0;
      int_cnt       <= '0;
      seen_start    <= 1'b0;
    end else if (frozen || finish) begin
      // Statistics freeze at the first sampled finish; only the pulses are forced low.
      frozen    <= 1'b1;
      start_evt <= 1'b0;
      done_evt  <= 1'b0;
    end else begin
      start_evt   <= start_acc;
      done_evt    <= complete;
      cycle_count <= inc_c(cycle_count);

      if (ap_ready) ready_count <= inc_t(ready_count);
      if (st == IDLE && ap_done && !ap_start) spurious_done <= 1'b1;
      if (st == WAIT_CONT && !ap_continue) stall_cycles <= inc_c(stall_cycles);

      if (start_acc) begin
        int_cnt    <= C_ONE;
        seen_start <= 1'b1;
        if (seen_start) last_interval <= int_cnt;
      end else begin
        int_cnt <= inc_c(int_cnt);
      end

      if (start_acc || st == RUN) lat_cnt <= lat_now;

      if (complete) begin
        last_latency <= lat_now;
        txn_count    <= inc_t(txn_count);
        if (lat_now < min_latency) min_latency <= lat_now;
        if (lat_now > max_latency) max_latency <= lat_now;
      end

      case (st)
        IDLE: begin
          if (start_acc) begin
            if (!ap_done)        st <= RUN;
            else if (!ap_continue) st <= WAIT_CONT;
          end
        end
        RUN: begin
          if (ap_done) st <= ap_continue ? IDLE : WAIT_CONT;
        end
        WAIT_CONT: begin
          if (ap_continue) st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nodf_handshake_monitor.sv
// Scoreboard bench for nodf_handshake_monitor: expected latencies are queued when done is
// driven and compared when done_evt appears; each scenario task checks its own outputs.
module tb_nodf_handshake_monitor;

  localparam int CNT_W = 8;
  localparam int TXN_W = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             ap_start = 1'b0;
  logic             ap_ready = 1'b0;
  logic             ap_done = 1'b0;
  logic             ap_continue = 1'b1;
  logic             finish = 1'b0;
  logic [1:0]       state;
  logic             start_evt;
  logic             done_evt;
  logic [TXN_W-1:0] txn_count;
  logic [TXN_W-1:0] ready_count;
  logic [CNT_W-1:0] last_latency;
  logic [CNT_W-1:0] min_latency;
  logic [CNT_W-1:0] max_latency;
  logic [CNT_W-1:0] last_interval;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] cycle_count;
  logic             frozen;
  logic             spurious_done;

  int asserts = 0;
  int fails   = 0;
  int tb_cycles = 0;
  logic [CNT_W-1:0] exp_lat[$];

  nodf_handshake_monitor #(.CNT_W(CNT_W), .TXN_W(TXN_W)) dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish), .state(state),
    .start_evt(start_evt), .done_evt(done_evt), .txn_count(txn_count),
    .ready_count(ready_count), .last_latency(last_latency), .min_latency(min_latency),
    .max_latency(max_latency), .last_interval(last_interval), .stall_cycles(stall_cycles),
    .cycle_count(cycle_count), .frozen(frozen), .spurious_done(spurious_done)
  );

  always #5 clock = ~clock;

  // Scoreboard: every done_evt pulse must match the oldest queued latency.
  always @(negedge clock) begin
    if (!reset && done_evt) begin
      asserts++;
      if (exp_lat.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_done got last_latency=%0d with no expected entry", last_latency);
      end else begin
        logic [CNT_W-1:0] e;
        e = exp_lat.pop_front();
        if (last_latency !== e) begin
          fails++;
          $display("FAIL sb_latency got=%0d exp=%0d", last_latency, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    if (!reset) tb_cycles++;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1; ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 1; finish = 0;
    exp_lat.delete();
    @(posedge clock); @(negedge clock);
    reset = 1'b0;
    tb_cycles = 0;
  endtask

  function automatic logic [CNT_W-1:0] sat_lat(input int lat);
    return (lat > 255) ? 8'hFF : CNT_W'(lat);
  endfunction

  // One transaction of the given inclusive latency, continue held high.
  task automatic run_txn(input int lat);
    ap_start = 1; ap_continue = 1; ap_done = (lat == 1);
    if (lat == 1) exp_lat.push_back(1);
    tick();
    ap_start = 0; ap_done = 0;
    if (lat > 1) begin
      repeat (lat - 2) tick();
      ap_done = 1;
      exp_lat.push_back(sat_lat(lat));
      tick();
      ap_done = 0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock);
    asserts++;
    if (state !== 2'd0 || txn_count !== '0 || ready_count !== '0 || last_latency !== '0 ||
        max_latency !== '0 || last_interval !== '0 || stall_cycles !== '0 ||
        cycle_count !== '0 || frozen !== 1'b0 || spurious_done !== 1'b0 ||
        start_evt !== 1'b0 || done_evt !== 1'b0) begin
      fails++;
      $display("FAIL reset_zero got state=%0d txn=%0d cyc=%0d frozen=%0b exp all zero", state, txn_count, cycle_count, frozen);
    end
    asserts++;
    if (min_latency !== 8'hFF) begin
      fails++; $display("FAIL reset_min got=%0h exp=ff", min_latency);
    end
    do_reset();
    repeat (5) tick();
    asserts++;
    if (cycle_count !== 8'd5) begin
      fails++; $display("FAIL reset_cycle_count got=%0d exp=5", cycle_count);
    end
  endtask

  task automatic test_latency();
    do_reset();
    ap_start = 1; tick(); ap_start = 0;
    asserts++;
    if (state !== 2'd1 || start_evt !== 1'b1) begin
      fails++; $display("FAIL lat_start got state=%0d start_evt=%0b exp 1/1", state, start_evt);
    end
    repeat (4) tick();
    ap_done = 1; exp_lat.push_back(6); tick(); ap_done = 0;
    asserts++;
    if (done_evt !== 1'b1 || state !== 2'd0 || txn_count !== 4'd1) begin
      fails++; $display("FAIL lat_done got done_evt=%0b state=%0d txn=%0d exp 1/0/1", done_evt, state, txn_count);
    end
    asserts++;
    if (min_latency !== 8'd6 || max_latency !== 8'd6) begin
      fails++; $display("FAIL lat_minmax got min=%0d max=%0d exp 6/6", min_latency, max_latency);
    end
    tick();
    asserts++;
    if (done_evt !== 1'b0) begin
      fails++; $display("FAIL lat_pulse got done_evt=%0b exp 0", done_evt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ap_start = 1; ap_done = 1; exp_lat.push_back(1); tick(); ap_start = 0; ap_done = 0;
    asserts++;
    if (state !== 2'd0 || txn_count !== 4'd1 || last_interval !== 8'd0) begin
      fails++; $display("FAIL b2b_first got state=%0d txn=%0d interval=%0d exp 0/1/0", state, txn_count, last_interval);
    end
    repeat (2) tick();
    ap_start = 1; ap_done = 1; exp_lat.push_back(1); tick(); ap_start = 0; ap_done = 0;
    asserts++;
    if (last_interval !== 8'd3 || txn_count !== 4'd2 || last_latency !== 8'd1) begin
      fails++; $display("FAIL b2b_second got interval=%0d txn=%0d lat=%0d exp 3/2/1", last_interval, txn_count, last_latency);
    end
  endtask

  task automatic test_stall();
    do_reset();
    ap_start = 1; tick(); ap_start = 0;
    ap_done = 1; ap_continue = 0; exp_lat.push_back(2); tick(); ap_done = 0;
    asserts++;
    if (state !== 2'd2) begin
      fails++; $display("FAIL stall_enter got state=%0d exp 2", state);
    end
    ap_start = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      asserts++;
      if (state !== 2'd2 || start_evt !== 1'b0) begin
        fails++; $display("FAIL stall_hold cycle %0d got state=%0d start_evt=%0b exp 2/0", i, state, start_evt);
      end
    end
    ap_start = 0; ap_continue = 1; tick();
    asserts++;
    if (state !== 2'd0 || stall_cycles !== 8'd4 || txn_count !== 4'd1) begin
      fails++; $display("FAIL stall_exit got state=%0d stall=%0d txn=%0d exp 0/4/1", state, stall_cycles, txn_count);
    end
  endtask

  task automatic test_minmax_spurious();
    do_reset();
    run_txn(10); tick();
    run_txn(3);  tick();
    run_txn(7);  tick();
    asserts++;
    if (min_latency !== 8'd3 || max_latency !== 8'd10 || last_latency !== 8'd7 || txn_count !== 4'd3) begin
      fails++; $display("FAIL minmax got min=%0d max=%0d last=%0d txn=%0d exp 3/10/7/3", min_latency, max_latency, last_latency, txn_count);
    end
    ap_done = 1; tick(); ap_done = 0;
    asserts++;
    if (spurious_done !== 1'b1 || txn_count !== 4'd3 || done_evt !== 1'b0 || state !== 2'd0) begin
      fails++; $display("FAIL spurious got flag=%0b txn=%0d done_evt=%0b state=%0d exp 1/3/0/0", spurious_done, txn_count, done_evt, state);
    end
  endtask

  task automatic test_ready_only();
    do_reset();
    ap_continue = 0;
    for (int i = 0; i < 3; i++) begin
      ap_ready = 1; tick(); ap_ready = 0; tick(); tick();
    end
    asserts++;
    if (ready_count !== 4'd3 || txn_count !== 4'd0 || state !== 2'd0 || spurious_done !== 1'b0) begin
      fails++; $display("FAIL ready_only got ready=%0d txn=%0d state=%0d spur=%0b exp 3/0/0/0", ready_count, txn_count, state, spurious_done);
    end
    ap_ready = 1; repeat (20) tick(); ap_ready = 0;
    asserts++;
    if (ready_count !== 4'hF) begin
      fails++; $display("FAIL ready_saturate got=%0d exp=15", ready_count);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    run_txn(300); tick();
    asserts++;
    if (last_latency !== 8'hFF || max_latency !== 8'hFF || cycle_count !== 8'hFF) begin
      fails++; $display("FAIL lat_saturate got last=%0d max=%0d cyc=%0d exp 255/255/255", last_latency, max_latency, cycle_count);
    end
    for (int i = 0; i < 17; i++) begin
      run_txn(1); tick();
    end
    asserts++;
    if (txn_count !== 4'hF || min_latency !== 8'd1) begin
      fails++; $display("FAIL txn_saturate got txn=%0d min=%0d exp 15/1", txn_count, min_latency);
    end
  endtask

  task automatic test_finish();
    logic [CNT_W-1:0] exp_cc;
    do_reset();
    run_txn(4); tick();
    ap_start = 1; tick(); ap_start = 0; tick();
    finish = 1; exp_cc = CNT_W'(tb_cycles); tick(); finish = 0;
    asserts++;
    if (frozen !== 1'b1 || state !== 2'd1) begin
      fails++; $display("FAIL finish_frozen got frozen=%0b state=%0d exp 1/1", frozen, state);
    end
    for (int i = 0; i < 3; i++) begin
      ap_done = 1; ap_start = 1; ap_ready = 1; tick();
      ap_done = 0; ap_start = 0; ap_ready = 0; tick();
    end
    asserts++;
    if (txn_count !== 4'd1 || last_latency !== 8'd4 || ready_count !== 4'd0 ||
        state !== 2'd1 || done_evt !== 1'b0 || start_evt !== 1'b0) begin
      fails++; $display("FAIL finish_hold got txn=%0d last=%0d ready=%0d state=%0d exp 1/4/0/1", txn_count, last_latency, ready_count, state);
    end
    asserts++;
    if (cycle_count !== exp_cc || frozen !== 1'b1) begin
      fails++; $display("FAIL finish_cycles got=%0d exp=%0d frozen=%0b", cycle_count, exp_cc, frozen);
    end
    asserts++;
    if (exp_lat.size() != 0) begin
      fails++; $display("FAIL sb_leftover got %0d pending exp 0", exp_lat.size());
    end
    #2 reset = 1'b1; #1;
    asserts++;
    if (frozen !== 1'b0 || state !== 2'd0 || txn_count !== '0 || cycle_count !== '0 ||
        min_latency !== 8'hFF || max_latency !== '0) begin
      fails++; $display("FAIL finish_reset got frozen=%0b state=%0d txn=%0d cyc=%0d min=%0h exp 0/0/0/0/ff", frozen, state, txn_count, cycle_count, min_latency);
    end
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_stall();
    test_minmax_spurious();
    test_ready_only();
    test_saturation();
    test_finish();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
